axi_rd_tmout_responder: RTL and testbench

AXI_RD_TMOUT_RESPONDER -- requirements
Module: axi_rd_tmout_responder

---
 rtl/axi_rd_tmout_responder_pkg.sv | 23 ++
 rtl/axi_rd_tmout_responder_us_timer.sv | 68 ++++++
 rtl/axi_rd_tmout_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_axi_rd_tmout_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_tmout_responder_pkg.sv
// ---------------------------------------------------------------------------
// axi_rd_tmout_responder_pkg
//   Shared definitions for the AXI read timeout responder:
//   - FSM state encoding used by the top-level controller
//   - AXI response codes
//   - saturation limit of the timeout event counter
// ---------------------------------------------------------------------------
package axi_rd_tmout_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AR_FWD = 3'd1,
        ST_R_WAIT = 3'd2,
        ST_R_RESP = 3'd3,
        ST_DRAIN  = 3'd4
    } state_e;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;

    localparam logic [15:0] TMOUT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/axi_rd_tmout_responder_us_timer.sv
// ---------------------------------------------------------------------------
// axi_rd_us_timer
//   Microsecond timeout timer. A prescaler divides clks down to a 1 us tick
//   and a 16-bit counter accumulates elapsed microseconds while enabled.
//
// Ports
//   clks      in   clock
//   reset     in   asynchronous active-high reset
//   en_i      in   count while high
//   clr_i     in   synchronous clear of prescaler and us counter
//   cfg_i     in   timeout in microseconds, 0 = never expire
//   expire_o  out  high on the cycle whose closing tick brings the us
//                  counter up to cfg_i
// ---------------------------------------------------------------------------
module axi_rd_us_timer #(
    parameter int TIMER_1US_CFG = 200
) (
    input  logic        clks,
    input  logic        reset,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [15:0] cfg_i,
    output logic        expire_o
);
    import axi_rd_tmout_responder_pkg::*;

    localparam int            PW         = (TIMER_1US_CFG > 1) ? $clog2(TIMER_1US_CFG) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_1US_CFG - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [15:0]   us_q;
    logic [15:0]   us_d;
    logic          tick;

    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            us_q    <= '0;
        end else begin
            presc_q <= presc_d;
            us_q    <= us_d;
        end
    end

    // Expiry is decoded one cycle early (on the terminal tick that will
    // make the us counter equal cfg) so the registered response in the
    // parent appears exactly cfg*TIMER_1US_CFG cycles after counting starts.
    always_comb begin
        tick     = en_i && (presc_q == PRESC_LAST);
        presc_d  = presc_q;
        us_d     = us_q;
        if (clr_i) begin
            presc_d = '0;
            us_d    = '0;
        end else if (en_i) begin
            if (tick) begin
                presc_d = '0;
                us_d    = us_q + 16'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        expire_o = tick && (cfg_i != 16'd0) &&
                   (({1'b0, us_q} + 17'd1) == {1'b0, cfg_i});
    end

endmodule

// File: rtl/axi_rd_tmout_responder.sv
// ---------------------------------------------------------------------------
// axi_rd_tmout_responder
//   AXI4-Lite read bridge with a timeout. A single read is forwarded from
//   the upstream slave port to the downstream master port. If the
//   downstream side does not complete within the latched timeout, an
//   SLVERR response carrying ERR_DATA is returned upstream and the late
//   downstream transaction is drained and discarded afterwards.
//
// Ports
//   clks, reset            clock, asynchronous active-high reset
//   reg_tmout_us_cfg_i     timeout in microseconds (0 = disabled)
//   s_ar*_i/_o             upstream AR channel (slave)
//   s_r*_i/_o              upstream R channel (slave)
//   m_ar*_i/_o             downstream AR channel (master)
//   m_r*_i/_o              downstream R channel (master)
//   tmout_flag_o           one-cycle pulse per timed-out read
//   tmout_cnt_o            saturating count of timed-out reads
// ---------------------------------------------------------------------------
module axi_rd_tmout_responder #(
    parameter int          TIMER_1US_CFG = 200,
    parameter logic [31:0] ERR_DATA      = 32'hDEAD_BEEF
) (
    input  logic        clks,
    input  logic        reset,
    input  logic [15:0] reg_tmout_us_cfg_i,
    input  logic        s_arvalid_i,
    output logic        s_arready_o,
    input  logic [31:0] s_araddr_i,
    output logic        s_rvalid_o,
    input  logic        s_rready_i,
    output logic [31:0] s_rdata_o,
    output logic [1:0]  s_rresp_o,
    output logic        m_arvalid_o,
    input  logic        m_arready_i,
    output logic [31:0] m_araddr_o,
    input  logic        m_rvalid_i,
    output logic        m_rready_o,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    output logic        tmout_flag_o,
    output logic [15:0] tmout_cnt_o
);
    import axi_rd_tmout_responder_pkg::*;

    state_e      state_q,      state_d;
    logic        s_arready_q,  s_arready_d;
    logic        s_rvalid_q,   s_rvalid_d;
    logic [31:0] s_rdata_q,    s_rdata_d;
    logic [1:0]  s_rresp_q,    s_rresp_d;
    logic        m_arvalid_q,  m_arvalid_d;
    logic [31:0] m_araddr_q,   m_araddr_d;
    logic        m_rready_q,   m_rready_d;
    logic        tmout_flag_q, tmout_flag_d;
    logic [15:0] tmout_cnt_q,  tmout_cnt_d;
    logic [15:0] cfg_q,        cfg_d;
    logic        drain_q,      drain_d;

    logic        timer_en;
    logic        timer_expire;
    logic        timeout_hit;

    // The timer runs only while the downstream side owes us something
    // and is held cleared everywhere else, so each read starts from zero.
    assign timer_en = (state_q == ST_AR_FWD) || (state_q == ST_R_WAIT);

    axi_rd_us_timer #(
        .TIMER_1US_CFG (TIMER_1US_CFG)
    ) u_us_timer (
        .clks     (clks),
        .reset    (reset),
        .en_i     (timer_en),
        .clr_i    (!timer_en),
        .cfg_i    (cfg_q),
        .expire_o (timer_expire)
    );

    // A completing handshake on the expiry cycle takes priority, so the
    // timeout only counts when the awaited handshake is absent.
    assign timeout_hit = timer_expire &&
                         (((state_q == ST_AR_FWD) && !m_arready_i) ||
                          ((state_q == ST_R_WAIT) && !m_rvalid_i));

    // State and output registers.
    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            s_arready_q  <= 1'b1;
            s_rvalid_q   <= 1'b0;
            s_rdata_q    <= '0;
            s_rresp_q    <= RESP_OKAY;
            m_arvalid_q  <= 1'b0;
            m_araddr_q   <= '0;
            m_rready_q   <= 1'b0;
            tmout_flag_q <= 1'b0;
            tmout_cnt_q  <= '0;
            cfg_q        <= '0;
            drain_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_arready_q  <= s_arready_d;
            s_rvalid_q   <= s_rvalid_d;
            s_rdata_q    <= s_rdata_d;
            s_rresp_q    <= s_rresp_d;
            m_arvalid_q  <= m_arvalid_d;
            m_araddr_q   <= m_araddr_d;
            m_rready_q   <= m_rready_d;
            tmout_flag_q <= tmout_flag_d;
            tmout_cnt_q  <= tmout_cnt_d;
            cfg_q        <= cfg_d;
            drain_q      <= drain_d;
        end
    end

    // Next-state logic. DRAIN is entered only when a timeout left a
    // downstream read outstanding; it has no timeout of its own.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (s_arvalid_i && s_arready_q) state_d = ST_AR_FWD;
            end
            ST_AR_FWD: begin
                if (m_arready_i)      state_d = ST_R_WAIT;
                else if (timeout_hit) state_d = ST_R_RESP;
            end
            ST_R_WAIT: begin
                if (m_rvalid_i || timeout_hit) state_d = ST_R_RESP;
            end
            ST_R_RESP: begin
                if (s_rready_i) state_d = drain_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (!m_arvalid_q && m_rready_q && m_rvalid_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered output logic. m_arvalid behaves as the "AR still owed
    // downstream" flag: once raised it only drops on m_arready, whatever
    // state the controller has moved on to.
    always_comb begin
        s_rvalid_d   = s_rvalid_q;
        s_rdata_d    = s_rdata_q;
        s_rresp_d    = s_rresp_q;
        m_arvalid_d  = m_arvalid_q;
        m_araddr_d   = m_araddr_q;
        m_rready_d   = m_rready_q;
        tmout_flag_d = 1'b0;
        tmout_cnt_d  = tmout_cnt_q;
        cfg_d        = cfg_q;
        drain_d      = drain_q;
        s_arready_d  = (state_d == ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (s_arvalid_i && s_arready_q) begin
                    m_arvalid_d = 1'b1;
                    m_araddr_d  = s_araddr_i;
                    cfg_d       = reg_tmout_us_cfg_i;
                end
            end
            ST_AR_FWD: begin
                if (m_arready_i) begin
                    m_arvalid_d = 1'b0;
                    m_rready_d  = 1'b1;
                end
            end
            ST_R_WAIT: begin
                if (m_rvalid_i) begin
                    s_rvalid_d = 1'b1;
                    s_rdata_d  = m_rdata_i;
                    s_rresp_d  = m_rresp_i;
                    m_rready_d = 1'b0;
                end
            end
            ST_R_RESP: begin
                if (m_arvalid_q && m_arready_i) m_arvalid_d = 1'b0;
                if (s_rready_i) begin
                    s_rvalid_d = 1'b0;
                    if (drain_q) m_rready_d = !m_arvalid_d;
                end
            end
            ST_DRAIN: begin
                if (m_arvalid_q) begin
                    if (m_arready_i) begin
                        m_arvalid_d = 1'b0;
                        m_rready_d  = 1'b1;
                    end
                end else if (m_rready_q && m_rvalid_i) begin
                    m_rready_d = 1'b0;
                    drain_d    = 1'b0;
                end
            end
            default: begin
                m_arvalid_d = 1'b0;
                m_rready_d  = 1'b0;
                s_rvalid_d  = 1'b0;
                drain_d     = 1'b0;
            end
        endcase

        // Timeout response overrides the normal path for this read.
        if (timeout_hit) begin
            s_rvalid_d   = 1'b1;
            s_rdata_d    = ERR_DATA;
            s_rresp_d    = RESP_SLVERR;
            m_rready_d   = 1'b0;
            drain_d      = 1'b1;
            tmout_flag_d = 1'b1;
            if (tmout_cnt_q != TMOUT_CNT_MAX) tmout_cnt_d = tmout_cnt_q + 16'd1;
        end
    end

    assign s_arready_o  = s_arready_q;
    assign s_rvalid_o   = s_rvalid_q;
    assign s_rdata_o    = s_rdata_q;
    assign s_rresp_o    = s_rresp_q;
    assign m_arvalid_o  = m_arvalid_q;
    assign m_araddr_o   = m_araddr_q;
    assign m_rready_o   = m_rready_q;
    assign tmout_flag_o = tmout_flag_q;
    assign tmout_cnt_o  = tmout_cnt_q;

endmodule

// File: tb/tb_axi_rd_tmout_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_tmout_responder
//   Directed bench for the AXI read timeout responder with a 10-cycle
//   microsecond prescaler. Cycle E below is the first cycle in which the
//   DUT presents m_arvalid after accepting an upstream read.
// ---------------------------------------------------------------------------
module tb_axi_rd_tmout_responder;

    localparam int          TIMER_CFG = 10;
    localparam logic [31:0] ERR_WORD  = 32'hDEAD_BEEF;

    logic        clks;
    logic        reset;
    logic [15:0] tmoutCfg;
    logic        sArvalid;
    logic        sArready;
    logic [31:0] sAraddr;
    logic        sRvalid;
    logic        sRready;
    logic [31:0] sRdata;
    logic [1:0]  sRresp;
    logic        mArvalid;
    logic        mArready;
    logic [31:0] mAraddr;
    logic        mRvalid;
    logic        mRready;
    logic [31:0] mRdata;
    logic [1:0]  mRresp;
    logic        tmoutFlag;
    logic [15:0] tmoutCnt;

    int testCount  = 0;
    int failCount  = 0;
    int flagPulses = 0;
    int waited;

    axi_rd_tmout_responder #(
        .TIMER_1US_CFG (TIMER_CFG),
        .ERR_DATA      (ERR_WORD)
    ) dut (
        .clks               (clks),
        .reset              (reset),
        .reg_tmout_us_cfg_i (tmoutCfg),
        .s_arvalid_i        (sArvalid),
        .s_arready_o        (sArready),
        .s_araddr_i         (sAraddr),
        .s_rvalid_o         (sRvalid),
        .s_rready_i         (sRready),
        .s_rdata_o          (sRdata),
        .s_rresp_o          (sRresp),
        .m_arvalid_o        (mArvalid),
        .m_arready_i        (mArready),
        .m_araddr_o         (mAraddr),
        .m_rvalid_i         (mRvalid),
        .m_rready_o         (mRready),
        .m_rdata_i          (mRdata),
        .m_rresp_i          (mRresp),
        .tmout_flag_o       (tmoutFlag),
        .tmout_cnt_o        (tmoutCnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clks = 1'b0;
    always #5 clks = ~clks;

    // Count every cycle in which the timeout pulse is visible.
    always @(negedge clks) begin
        if (tmoutFlag === 1'b1) flagPulses++;
    end

    // One comparison: count it, report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance n clock edges, landing 1 time unit after the last edge.
    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clks);
            #1;
        end
    endtask

    // Present one upstream read; returns at cycle E.
    task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] cfg);
        checkOutput("ar_ready_before_req", 32'(sArready), 32'd1);
        sArvalid = 1'b1;
        sAraddr  = addr;
        tmoutCfg = cfg;
        waitCycles(1);
        sArvalid = 1'b0;
        sAraddr  = 32'h0;
        checkOutput("m_arvalid_next_cycle", 32'(mArvalid), 32'd1);
        checkOutput("m_araddr_forwarded", mAraddr, addr);
        checkOutput("s_arready_closed", 32'(sArready), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        tmoutCfg = 16'd0;
        sArvalid = 1'b0;
        sAraddr  = 32'h0;
        sRready  = 1'b0;
        mArready = 1'b0;
        mRvalid  = 1'b0;
        mRdata   = 32'h0;
        mRresp   = 2'b00;

        // Reset values
        waitCycles(2);
        checkOutput("rst_s_arready", 32'(sArready), 32'd1);
        checkOutput("rst_s_rvalid", 32'(sRvalid), 32'd0);
        checkOutput("rst_m_arvalid", 32'(mArvalid), 32'd0);
        checkOutput("rst_m_rready", 32'(mRready), 32'd0);
        checkOutput("rst_tmout_cnt", 32'(tmoutCnt), 32'd0);
        reset = 1'b0;
        waitCycles(1);

        // Normal read, cfg=5, R three cycles after AR acceptance
        applyStimulus(32'h0000_1000, 16'd5);
        mArready = 1'b1;
        waitCycles(1);
        mArready = 1'b0;
        checkOutput("t1_m_arvalid_dropped", 32'(mArvalid), 32'd0);
        checkOutput("t1_m_rready", 32'(mRready), 32'd1);
        waitCycles(2);
        mRvalid = 1'b1;
        mRdata  = 32'h1234_5678;
        mRresp  = 2'b00;
        waitCycles(1);
        mRvalid = 1'b0;
        mRdata  = 32'h0;
        checkOutput("t1_s_rvalid", 32'(sRvalid), 32'd1);
        checkOutput("t1_s_rdata", sRdata, 32'h1234_5678);
        checkOutput("t1_s_rresp", 32'(sRresp), 32'd0);
        checkOutput("t1_m_rready_off", 32'(mRready), 32'd0);
        waitCycles(1);
        checkOutput("t1_s_rvalid_held", 32'(sRvalid), 32'd1);
        checkOutput("t1_s_rdata_held", sRdata, 32'h1234_5678);
        sRready = 1'b1;
        waitCycles(1);
        sRready = 1'b0;
        checkOutput("t1_s_rvalid_done", 32'(sRvalid), 32'd0);
        checkOutput("t1_back_idle", 32'(sArready), 32'd1);
        checkOutput("t1_no_flag", 32'(flagPulses), 32'd0);
        checkOutput("t1_cnt", 32'(tmoutCnt), 32'd0);

        // Timeout in R_WAIT, cfg=2, cfg input changed after acceptance
        applyStimulus(32'h0000_2000, 16'd2);
        tmoutCfg = 16'd0;
        mArready = 1'b1;
        waitCycles(1);
        mArready = 1'b0;
        waited = 1;
        while (tmoutFlag !== 1'b1 && waited < 60) begin
            waitCycles(1);
            waited++;
        end
        checkOutput("t2_flag_latency", 32'(waited), 32'd20);
        checkOutput("t2_s_rvalid", 32'(sRvalid), 32'd1);
        checkOutput("t2_s_rdata", sRdata, 32'hDEAD_BEEF);
        checkOutput("t2_s_rresp", 32'(sRresp), 32'd2);
        checkOutput("t2_cnt", 32'(tmoutCnt), 32'd1);
        checkOutput("t2_m_rready_off", 32'(mRready), 32'd0);
        waitCycles(1);
        checkOutput("t2_flag_pulse", 32'(tmoutFlag), 32'd0);
        checkOutput("t2_s_rvalid_held", 32'(sRvalid), 32'd1);
        sRready = 1'b1;
        waitCycles(1);
        sRready = 1'b0;
        checkOutput("t2_drain_s_rvalid", 32'(sRvalid), 32'd0);
        checkOutput("t2_drain_s_arready", 32'(sArready), 32'd0);
        checkOutput("t2_drain_m_rready", 32'(mRready), 32'd1);
        waitCycles(28);
        checkOutput("t2_drain_still_busy", 32'(sArready), 32'd0);
        mRvalid = 1'b1;
        mRdata  = 32'hCAFE_F00D;
        waitCycles(1);
        mRvalid = 1'b0;
        mRdata  = 32'h0;
        checkOutput("t2_idle_after_drain", 32'(sArready), 32'd1);
        checkOutput("t2_late_r_dropped", 32'(sRvalid), 32'd0);
        checkOutput("t2_m_rready_idle", 32'(mRready), 32'd0);
        checkOutput("t2_single_pulse", 32'(flagPulses), 32'd1);

        // Timeout in AR_FWD, m_arready low for 40 cycles
        applyStimulus(32'h0000_3000, 16'd2);
        waited = 0;
        while (tmoutFlag !== 1'b1 && waited < 60) begin
            waitCycles(1);
            waited++;
        end
        checkOutput("t3_flag_latency", 32'(waited), 32'd20);
        checkOutput("t3_s_rdata", sRdata, 32'hDEAD_BEEF);
        checkOutput("t3_s_rresp", 32'(sRresp), 32'd2);
        checkOutput("t3_m_arvalid_kept", 32'(mArvalid), 32'd1);
        checkOutput("t3_cnt", 32'(tmoutCnt), 32'd2);
        sRready = 1'b1;
        waitCycles(1);
        sRready = 1'b0;
        checkOutput("t3_drain_m_rready_off", 32'(mRready), 32'd0);
        waitCycles(18);
        checkOutput("t3_m_arvalid_e39", 32'(mArvalid), 32'd1);
        checkOutput("t3_m_araddr_e39", mAraddr, 32'h0000_3000);
        mArready = 1'b1;
        waitCycles(1);
        mArready = 1'b0;
        checkOutput("t3_m_arvalid_done", 32'(mArvalid), 32'd0);
        checkOutput("t3_m_rready_on", 32'(mRready), 32'd1);
        checkOutput("t3_still_draining", 32'(sArready), 32'd0);
        waitCycles(2);
        mRvalid = 1'b1;
        waitCycles(1);
        mRvalid = 1'b0;
        checkOutput("t3_idle", 32'(sArready), 32'd1);
        checkOutput("t3_pulses", 32'(flagPulses), 32'd2);

        // R handshake on the cycle the timeout would be decided
        applyStimulus(32'h0000_4000, 16'd2);
        mArready = 1'b1;
        waitCycles(1);
        mArready = 1'b0;
        waitCycles(18);
        checkOutput("t4_no_resp_yet", 32'(sRvalid), 32'd0);
        checkOutput("t4_m_rready", 32'(mRready), 32'd1);
        mRvalid = 1'b1;
        mRdata  = 32'h5A5A_0001;
        mRresp  = 2'b01;
        waitCycles(1);
        mRvalid = 1'b0;
        mRdata  = 32'h0;
        mRresp  = 2'b00;
        checkOutput("t4_s_rvalid", 32'(sRvalid), 32'd1);
        checkOutput("t4_s_rdata", sRdata, 32'h5A5A_0001);
        checkOutput("t4_s_rresp", 32'(sRresp), 32'd1);
        checkOutput("t4_no_flag", 32'(tmoutFlag), 32'd0);
        checkOutput("t4_cnt_same", 32'(tmoutCnt), 32'd2);
        sRready = 1'b1;
        waitCycles(1);
        sRready = 1'b0;
        checkOutput("t4_idle_no_drain", 32'(sArready), 32'd1);

        // Timeout disabled, R after 5000 cycles
        applyStimulus(32'h0000_5000, 16'd0);
        tmoutCfg = 16'd1;
        mArready = 1'b1;
        waitCycles(1);
        mArready = 1'b0;
        waitCycles(4999);
        mRvalid = 1'b1;
        mRdata  = 32'h0000_5000;
        waitCycles(1);
        mRvalid = 1'b0;
        mRdata  = 32'h0;
        checkOutput("t5_s_rvalid", 32'(sRvalid), 32'd1);
        checkOutput("t5_s_rdata", sRdata, 32'h0000_5000);
        checkOutput("t5_s_rresp", 32'(sRresp), 32'd0);
        checkOutput("t5_pulses", 32'(flagPulses), 32'd2);
        sRready = 1'b1;
        waitCycles(1);
        sRready = 1'b0;

        // Reset asserted while in R_WAIT
        applyStimulus(32'h0000_6000, 16'd3);
        mArready = 1'b1;
        waitCycles(1);
        mArready = 1'b0;
        waitCycles(1);
        checkOutput("t6_in_r_wait", 32'(mRready), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_s_arready", 32'(sArready), 32'd1);
        checkOutput("t6_s_rvalid", 32'(sRvalid), 32'd0);
        checkOutput("t6_m_arvalid", 32'(mArvalid), 32'd0);
        checkOutput("t6_m_rready", 32'(mRready), 32'd0);
        checkOutput("t6_s_rdata", sRdata, 32'h0);
        checkOutput("t6_s_rresp", 32'(sRresp), 32'd0);
        checkOutput("t6_m_araddr", mAraddr, 32'h0);
        checkOutput("t6_flag", 32'(tmoutFlag), 32'd0);
        checkOutput("t6_cnt", 32'(tmoutCnt), 32'd0);
        waitCycles(2);
        reset = 1'b0;
        waitCycles(3);
        checkOutput("t6_no_stale_resp", 32'(sRvalid), 32'd0);
        checkOutput("t6_idle_after", 32'(sArready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
